// File: rtl/riscv_instr_queue.sv
// Instruction queue feeding riscv_decoder.
// In-order FIFO of {pc, instr} pairs with valid/ready on both sides and a
// one-cycle flush for redirects. Status flags are derived from the entry count
// alone, so a full queue never accepts in the same cycle it is popped.
module riscv_instr_queue #(
   parameter int unsigned DEPTH = 4,   // power of two, >= 2
   parameter int unsigned XLEN  = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [XLEN-1:0]         in_pc_i,
   input  logic [31:0]             in_instr_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [XLEN-1:0]         out_pc_o,
   output logic [31:0]             out_instr_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   localparam logic [PW-1:0] PtrOne    = PW'(1);
   localparam logic [PW:0]   CntOne    = (PW + 1)'(1);
   localparam logic [PW:0]   CntFull   = (PW + 1)'(DEPTH);

   logic [XLEN-1:0] pc_q    [DEPTH];
   logic [31:0]     instr_q [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]     count_q,  count_d;
   logic            push, pop;

   // Handshake qualification; flags depend on count only.
   always_comb begin
      in_ready_o  = (count_q != CntFull);
      out_valid_o = (count_q != '0);
      push        = in_valid_i & in_ready_o;
      pop         = out_valid_o & out_ready_i;
   end

   // Next-state for pointers and count; flush overrides any transfer.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
         if (push && !pop) begin
            count_d = count_q + CntOne;
         end else if (pop && !push) begin
            count_d = count_q - CntOne;
         end
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; flush leaves contents untouched, reset clears them.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else if (push && !flush_i) begin
         pc_q[wr_ptr_q]    <= in_pc_i;
         instr_q[wr_ptr_q] <= in_instr_i;
      end
   end

   // Head entry is always visible, stale when the queue is empty.
   always_comb begin
      out_pc_o    = pc_q[rd_ptr_q];
      out_instr_o = instr_q[rd_ptr_q];
      count_o     = count_q;
   end

endmodule

// File: tb/tb_riscv_instr_queue.sv
// Bench for riscv_instr_queue: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_riscv_instr_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned XLEN  = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t model_q[$];

   riscv_instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_pc_i     (in_pc),
      .in_instr_i  (in_instr),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_pc_o    (out_pc),
      .out_instr_o (out_instr),
      .count_o     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance one clock; inputs change 2 time units after the edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Reference model: an ordered queue of accepted entries.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_q.delete();
         end else if (flush) begin
            model_q.delete();
         end else begin
            bit do_push, do_pop;
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = out_ready && (model_q.size() > 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({in_pc, in_instr});
         end
      end
   end

   // Every-cycle comparison against the model on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("model count", 64'(count), 64'(model_q.size()));
            chk("model out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            chk("model in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
            if (model_q.size() != 0) begin
               chk("model out_pc", 64'(out_pc), 64'(model_q[0].pc));
               chk("model out_instr", 64'(out_instr), 64'(model_q[0].instr));
            end
         end
      end
   end

   task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = ins;
      cyc();
      in_valid = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1 chk_en = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;

      // 1: idle after reset
      for (int i = 0; i < 10; i++) begin
         chk("idle count", 64'(count), 64'd0);
         chk("idle out_valid", 64'(out_valid), 64'd0);
         chk("idle in_ready", 64'(in_ready), 64'd1);
         chk("idle out_instr", 64'(out_instr), 64'd0);
         cyc();
      end

      // 2: single entry, visible one cycle later
      push_one(32'h8000_0000, 32'h0050_0093);
      chk("single out_valid", 64'(out_valid), 64'd1);
      chk("single out_pc", 64'(out_pc), 64'h8000_0000);
      chk("single out_instr", 64'(out_instr), 64'h0050_0093);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("single drained", 64'(count), 64'd0);

      // 3: fill, back-pressure, drain
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_pc    = 32'(4 * i);
         in_instr = 32'h0000_0013 + 32'(i << 20);
         cyc();
         if (i == 3) begin
            chk("fill in_ready", 64'(in_ready), 64'd0);
            chk("fill count", 64'(count), 64'd4);
         end
      end
      in_valid = 1'b0;
      chk("fifth rejected", 64'(count), 64'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain pc", 64'(out_pc), 64'(4 * i));
         cyc();
      end
      out_ready = 1'b0;
      chk("drain empty", 64'(count), 64'd0);
      chk("drain in_ready", 64'(in_ready), 64'd1);

      // 4: simultaneous push/pop at count 2, two pointer wraps
      push_one(32'h100, 32'h0010_0113);
      push_one(32'h104, 32'h0020_0113);
      for (int k = 0; k < 8; k++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_pc     = 32'h108 + 32'(4 * k);
         in_instr  = 32'h0000_0093 + 32'(k << 20);
         chk("pp head pc", 64'(out_pc), 64'(32'h100 + 32'(4 * k)));
         cyc();
         chk("pp count", 64'(count), 64'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("pp tail head", 64'(out_pc), 64'h120);

      // 5: flush wins over push and pop
      push_one(32'h200, 32'h0030_0113);
      chk("pre-flush count", 64'(count), 64'd3);
      flush     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_pc     = 32'hDEAD_0000;
      in_instr  = 32'h0BAD_0013;
      cyc();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("flush count", 64'(count), 64'd0);
      chk("flush out_valid", 64'(out_valid), 64'd0);
      cyc();
      chk("flush stays empty", 64'(count), 64'd0);
      push_one(32'h300, 32'h0040_0113);
      chk("post-flush pc", 64'(out_pc), 64'h300);
      chk("post-flush instr", 64'(out_instr), 64'h0040_0113);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;

      // 6: async reset between edges at count 3
      push_one(32'h400, 32'h1);
      push_one(32'h404, 32'h2);
      push_one(32'h408, 32'h3);
      chk("pre-reset count", 64'(count), 64'd3);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_pc     = 32'h40C;
      rst       = 1'b1;
      #1;
      chk("async count", 64'(count), 64'd0);
      chk("async out_valid", 64'(out_valid), 64'd0);
      chk("async out_pc", 64'(out_pc), 64'd0);
      chk("async out_instr", 64'(out_instr), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
      push_one(32'h8000_0000, 32'h0050_0093);
      chk("rerun out_valid", 64'(out_valid), 64'd1);
      chk("rerun out_pc", 64'(out_pc), 64'h8000_0000);
      chk("rerun out_instr", 64'(out_instr), 64'h0050_0093);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("rerun drained", 64'(count), 64'd0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
